rgb_mixer_nch: RTL
==================

// Module: rgb_mixer_nch
// PURPOSE
//  Parametrised successor to the 3-channel encoder-to-PWM mixer: NUM_CH independent channels,
//  each fed by one quadrature encoder (sync -> debounce -> x4 decode -> target level), with an
//  optional slew-limited fade toward the target and glitch-free PWM generation.
//  Sits at the user-project top, driving LED PWM pins and their active-low output enables.
// PARAMETERS
//  NUM_CH    3   number of channels (>=1)
//  WIDTH     8   level/counter width in bits (2..16)
//  DEB_LEN   8   consecutive equal synced samples required for a debounced change (>=2)
//  SATURATE  1   1: level clamps at 0 and 2^WIDTH-1; 0: level wraps modulo 2^WIDTH
//  FADE_DIV  0   0: PWM level follows target directly; N>0: step +-1 toward target every N clk
// PORTS
//  clk        in   1               system clock; single clock domain
//  reset_n    in   1               asynchronous, active-low reset
//  enable     in   1               global output enable
//  enc_a      in   NUM_CH          encoder A per channel (async, bouncy)
//  enc_b      in   NUM_CH          encoder B per channel (async, bouncy)
//  pwm_out    out  NUM_CH          PWM output per channel
//  out_en_b   out  NUM_CH          active-low pad enables, all bits = ~enable
//  level_out  out  NUM_CH*WIDTH    current (faded) level per channel, ch i at [i*WIDTH +: WIDTH]
// BEHAVIOUR
//  Reset (reset_n=0, async): all flops 0; target=level=0, pwm_out=0, PWM counter=0.
//   out_en_b is combinational ~enable. Release mid-operation: restart from 0, no partial periods.
//  Sync: 2-flop synchroniser per encoder input, reset value 0.
//  Debounce: debounced bit takes synced value on the clk after DEB_LEN consecutive equal samples;
//   otherwise holds. Latency input edge -> debounced edge = 2 + DEB_LEN clk with clean input.
//  Decode (x4): registered previous debounced a_p,b_p. If exactly one of a,b changed: step;
//   direction up when (a XOR b_p)=1, else down. Both changed in one clk: illegal, ignored.
//   Target updates the clk after the debounced edge.
//  Arithmetic: SATURATE=1: up at 2^WIDTH-1 holds, down at 0 holds. SATURATE=0: wraps (255+1=0).
//  Fade: one shared prescaler counts 0..FADE_DIV-1; on terminal count each channel's level moves
//   1 toward target (equal -> hold). FADE_DIV=0: level = target registered (1 clk latency).
//   Target changes mid-fade: fade retargets immediately, never overshoots.
//  PWM: shared counter cnt runs 0..2^WIDTH-2 (period 2^WIDTH-1 clk). Per channel, duty register
//   latches level when cnt = 2^WIDTH-2 (takes effect at next cnt=0 -> no runt pulses).
//   pwm_out = enable & (cnt < duty), registered. duty=0: always low; duty=2^WIDTH-1: always high.
//  enable=0: pwm_out forced 0 next clk; counters, targets and fades keep running.
// STRUCTURE
//  Shared package rgb_mixer_pkg: default WIDTH/NUM_CH/DEB_LEN constants, clog2 helper,
//   DIR_UP/DIR_DOWN encoding.
//  One sub-module mixer_channel: sync + debounce + decode + target/level regs + duty latch;
//   instantiated NUM_CH times via generate. Top holds PWM counter, fade prescaler, enable logic.
// TESTING  (NUM_CH=3, WIDTH=8, DEB_LEN=4, SATURATE=1, FADE_DIV=0 unless stated)
//  1 Reset: hold reset_n=0 mid-PWM -> pwm_out=000, level_out=0 immediately; out_en_b=~enable.
//  2 Ch1 4 clean up-steps (A leads B) -> level ch1=4, ch0/ch2=0; 3 down-steps -> ch1=1.
//  3 Bounce: 3-clk glitches on enc_a[0] -> no change; SATURATE=1 ch2 at 255 +1 -> 255; 0 -1 -> 0;
//    SATURATE=0 255+1 -> 0.
//  4 PWM: level 64 -> pwm_out[0] high exactly 64 of every 255 clk; level 0 -> never high;
//    255 -> always high; level change mid-period applies only from next cnt=0.
//  5 FADE_DIV=10: target 0->5 -> level 1..5 at 10-clk intervals; retarget to 2 at level 3 -> 2.
//  6 enable=0 while level=128 -> pwm_out=0 next clk, out_en_b=111; re-enable resumes at 128.

Source files
------------

// File: rtl/rgb_mixer_pkg.sv
// rgb_mixer_pkg: shared constants, direction
// encoding and a width helper for the mixer.
package rgb_mixer_pkg;

  localparam int DEF_NUM_CH  = 3;
  localparam int DEF_WIDTH   = 8;
  localparam int DEF_DEB_LEN = 8;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/mixer_channel.sv
// mixer_channel: one encoder path, sync, debounce,
// x4 decode, target/level registers and duty latch.
module mixer_channel
  import rgb_mixer_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEB_LEN  = DEF_DEB_LEN,
  parameter bit SATURATE = 1'b1,
  parameter int FADE_DIV = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_enc_a,
  input  logic             i_enc_b,
  input  logic             i_fade_tick,
  input  logic             i_duty_latch,
  output logic [WIDTH-1:0] o_level,
  output logic [WIDTH-1:0] o_duty
);

  localparam int CW = clog2(DEB_LEN);
  localparam logic [CW-1:0] CLAST = CW'(DEB_LEN - 1);
  localparam logic [WIDTH-1:0] LMAX = '1;
  localparam logic [WIDTH-1:0] LONE = WIDTH'(1);

  logic [1:0]       w_raw;
  logic [1:0]       r_s1;
  logic [1:0]       r_s2;
  logic [1:0]       r_deb;
  logic [1:0]       r_prev;
  logic [CW-1:0]    r_cnt [2];
  logic [WIDTH-1:0] r_target;
  logic [WIDTH-1:0] r_level;
  logic [WIDTH-1:0] r_duty;
  logic             w_step;
  dir_e             w_dir;

  assign w_raw = {i_enc_b, i_enc_a};

  // counter tracks consecutive samples that disagree with the debounced bit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_deb    <= '0;
      r_cnt[0] <= '0;
      r_cnt[1] <= '0;
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
      for (int k = 0; k < 2; k++) begin
        if (r_s2[k] == r_deb[k]) begin
          r_cnt[k] <= '0;
        end else if (r_cnt[k] == CLAST) begin
          r_deb[k] <= r_s2[k];
          r_cnt[k] <= '0;
        end else begin
          r_cnt[k] <= r_cnt[k] + CW'(1);
        end
      end
    end
  end

  assign w_step = (r_deb[0] ^ r_prev[0]) ^ (r_deb[1] ^ r_prev[1]);
  assign w_dir  = dir_e'(r_deb[0] ^ r_prev[1]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev   <= '0;
      r_target <= '0;
    end else begin
      r_prev <= r_deb;
      unique case (1'b1)
        (w_step && w_dir == DIR_UP): begin
          if (!(SATURATE && r_target == LMAX))
            r_target <= r_target + LONE;
        end
        (w_step && w_dir == DIR_DOWN): begin
          if (!(SATURATE && r_target == '0))
            r_target <= r_target - LONE;
        end
        default: ;
      endcase
    end
  end

  // duty only moves at period end so a period never gets cut short
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_level <= '0;
      r_duty  <= '0;
    end else begin
      if (FADE_DIV == 0) begin
        r_level <= r_target;
      end else if (i_fade_tick) begin
        if (r_level < r_target)
          r_level <= r_level + LONE;
        else if (r_level > r_target)
          r_level <= r_level - LONE;
      end
      if (i_duty_latch)
        r_duty <= r_level;
    end
  end

  assign o_level = r_level;
  assign o_duty  = r_duty;

endmodule

// File: rtl/rgb_mixer_nch.sv
// rgb_mixer_nch: NUM_CH encoder-driven LED channels
// with shared PWM counter and fade prescaler.
module rgb_mixer_nch
  import rgb_mixer_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEB_LEN  = DEF_DEB_LEN,
  parameter bit SATURATE = 1'b1,
  parameter int FADE_DIV = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [NUM_CH-1:0]       enc_a,
  input  logic [NUM_CH-1:0]       enc_b,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic [NUM_CH-1:0]       out_en_b,
  output logic [NUM_CH*WIDTH-1:0] level_out
);

  localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};
  localparam int PW = (FADE_DIV > 1) ? clog2(FADE_DIV) : 1;
  localparam logic [PW-1:0] PLAST = PW'((FADE_DIV > 0) ? FADE_DIV - 1 : 0);

  logic [WIDTH-1:0]  r_cnt;
  logic              w_cnt_last;
  logic [PW-1:0]     r_pre;
  logic              w_tick;
  logic [WIDTH-1:0]  w_duty [NUM_CH];
  logic [NUM_CH-1:0] r_pwm;

  // period is 2^WIDTH-1 so a full-scale duty stays high throughout
  assign w_cnt_last = (r_cnt == CNT_LAST);
  assign w_tick     = (FADE_DIV > 0) && (r_pre == PLAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_pre <= '0;
    end else begin
      r_cnt <= w_cnt_last ? '0 : r_cnt + WIDTH'(1);
      if (w_tick)
        r_pre <= '0;
      else if (FADE_DIV > 0)
        r_pre <= r_pre + PW'(1);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    mixer_channel #(
      .WIDTH    (WIDTH),
      .DEB_LEN  (DEB_LEN),
      .SATURATE (SATURATE),
      .FADE_DIV (FADE_DIV)
    ) u_ch (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_enc_a      (enc_a[i]),
      .i_enc_b      (enc_b[i]),
      .i_fade_tick  (w_tick),
      .i_duty_latch (w_cnt_last),
      .o_level      (level_out[i*WIDTH +: WIDTH]),
      .o_duty       (w_duty[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pwm <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        r_pwm[i] <= enable & (r_cnt < w_duty[i]);
    end
  end

  assign pwm_out  = r_pwm;
  assign out_en_b = {NUM_CH{~enable}};

endmodule
